// File: rtl/sv_uart_pkg.sv
// Shared types for the UART transmit scheduler and related routers.
// Holds the scheduler state enum, default header base and checksum step.
package sv_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CSUM
    } sched_state_t;

    localparam logic [7:0] SCHED_HDR_BASE = 8'hA0;

    // Running frame checksum: XOR over header and payload.
    function automatic logic [7:0] frame_csum(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/sv_uart_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr.
// Ports: req (requests), ptr (priority start) -> gnt (one-hot), id, any.
module sv_uart_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id,
    output logic          any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                id       = IW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sv_uart_tx_sched.sv
// Round-robin packet scheduler framing N_SRC byte streams onto one UART path.
// Ports: iclk/irst, s_axis_* per-source (N_SRC lanes), m_axis_* framed bytes,
//        ogrant one-hot owner (0 when idle), obusy high outside IDLE.
module sv_uart_tx_sched
    import sv_uart_pkg::*;
#(
    parameter int         N_SRC    = 4,
    parameter int         MAX_LEN  = 64,
    parameter logic [7:0] HDR_BASE = SCHED_HDR_BASE
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [N_SRC*8-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]   s_axis_tvalid,
    input  logic [N_SRC-1:0]   s_axis_tlast,
    output logic [N_SRC-1:0]   s_axis_tready,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [N_SRC-1:0]   ogrant,
    output logic               obusy
);

    localparam int IW = $clog2(N_SRC);
    localparam int LW = $clog2(MAX_LEN + 1);

    sched_state_t state_q, state_d;

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gid_q, gid_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       csum_q, csum_d;
    logic             vld_q, vld_d;
    logic             csum_out_q, csum_out_d;
    logic [LW-1:0]    len_q, len_d;

    logic [N_SRC-1:0] arb_gnt;
    logic [IW-1:0]    arb_id;
    logic             arb_any;

    logic             out_free;
    logic             beat;
    logic [7:0]       src_byte;
    logic             src_vld;
    logic             src_last;
    logic [LW-1:0]    len_inc;
    logic [7:0]       hdr_byte;

    sv_uart_rr_arbiter #(
        .N  (N_SRC),
        .IW (IW)
    ) u_arb (
        .req (s_axis_tvalid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .id  (arb_id),
        .any (arb_any)
    );

    // Output register can take a byte if empty or being drained now.
    assign out_free = !vld_q || m_axis_tready;
    assign src_byte = s_axis_tdata[8*int'(gid_q) +: 8];
    assign src_vld  = s_axis_tvalid[gid_q];
    assign src_last = s_axis_tlast[gid_q];
    assign beat     = (state_q == DATA) && out_free && src_vld;
    assign len_inc  = len_q + LW'(1);
    assign hdr_byte = HDR_BASE | 8'(arb_id);

    assign s_axis_tready = ((state_q == DATA) && out_free) ? gnt_q : '0;
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = vld_q;
    assign ogrant        = gnt_q;
    assign obusy         = (state_q != IDLE);

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gid_q      <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            csum_q     <= '0;
            vld_q      <= 1'b0;
            csum_out_q <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            csum_q     <= csum_d;
            vld_q      <= vld_d;
            csum_out_q <= csum_out_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        gnt_d      = gnt_q;
        data_d     = data_q;
        csum_d     = csum_q;
        vld_d      = vld_q;
        csum_out_d = csum_out_q;
        len_d      = len_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any && !vld_q) begin
                    gnt_d   = arb_gnt;
                    gid_d   = arb_id;
                    data_d  = hdr_byte;
                    csum_d  = hdr_byte;
                    vld_d   = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (m_axis_tready) begin
                    vld_d   = 1'b0;
                    len_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    data_d = src_byte;
                    vld_d  = 1'b1;
                    csum_d = frame_csum(csum_q, src_byte);
                    len_d  = len_inc;
                    // Full chunk splits the packet; remainder re-arbitrates.
                    if (src_last || len_inc == LW'(MAX_LEN)) begin
                        csum_out_d = 1'b0;
                        state_d    = CSUM;
                    end
                end else if (m_axis_tready) begin
                    vld_d = 1'b0;
                end
            end
            CSUM: begin
                // First load the trailer behind the last payload byte,
                // then wait for it to drain.
                if (!csum_out_q) begin
                    if (out_free) begin
                        data_d     = csum_q;
                        vld_d      = 1'b1;
                        csum_out_d = 1'b1;
                    end
                end else if (m_axis_tready) begin
                    vld_d      = 1'b0;
                    csum_out_d = 1'b0;
                    gnt_d      = '0;
                    ptr_d      = (gid_q == IW'(N_SRC - 1)) ? '0
                                                           : gid_q + IW'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sv_uart_tx_sched.sv
// Scoreboard bench for sv_uart_tx_sched: per-source frame model, RR order
// expectations, AXIS stall/ownership monitors, reset and split scenarios.
module tb_sv_uart_tx_sched;

    localparam int N       = 4;
    localparam int MAX_LEN = 64;
    localparam logic [7:0] HB = 8'hA0;

    logic             iclk = 1'b0;
    logic             irst = 1'b1;
    logic [N*8-1:0]   s_axis_tdata;
    logic [N-1:0]     s_axis_tvalid;
    logic [N-1:0]     s_axis_tlast;
    logic [N-1:0]     s_axis_tready;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [N-1:0]     ogrant;
    logic             obusy;

    sv_uart_tx_sched #(
        .N_SRC    (N),
        .MAX_LEN  (MAX_LEN),
        .HDR_BASE (HB)
    ) dut (
        .iclk          (iclk),
        .irst          (irst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .ogrant        (ogrant),
        .obusy         (obusy)
    );

    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q [N][$];
    logic [7:0] exp_q [N][$];
    int         flen  [N][$];
    int         order_q [$];
    logic [7:0] pkt [$];
    logic [N-1:0] fire = '0;
    logic       rdy_rand = 1'b0;
    logic       gap = 1'b0;
    int         beats = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: a packet becomes ceil(n/MAX_LEN) frames of
    // header, chunk, XOR of header and chunk.
    task automatic send(input int k);
        int off;
        int c;
        logic lst;
        logic [7:0] cs;
        for (int i = 0; i < pkt.size(); i++) begin
            lst = (i == pkt.size() - 1);
            src_q[k].push_back({lst, pkt[i]});
        end
        off = 0;
        while (off < pkt.size()) begin
            c = pkt.size() - off;
            if (c > MAX_LEN) c = MAX_LEN;
            cs = HB | 8'(k);
            exp_q[k].push_back(cs);
            for (int j = 0; j < c; j++) begin
                exp_q[k].push_back(pkt[off + j]);
                cs = cs ^ pkt[off + j];
            end
            exp_q[k].push_back(cs);
            flen[k].push_back(c + 2);
            off += c;
        end
    endtask

    function automatic bit tb_empty();
        for (int k = 0; k < N; k++)
            if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (n < budget && !(tb_empty() && !obusy && !m_axis_tvalid)) begin
            @(negedge iclk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required idle", nm, n);
        end
    endtask

    task automatic do_reset();
        @(posedge iclk);
        #2 irst = 1'b1;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_mdata", m_axis_tdata, 0);
        chk("rst_sready", s_axis_tready, 0);
        chk("rst_grant", ogrant, 0);
        chk("rst_busy", obusy, 0);
        irst = 1'b0;
    endtask

    // Source and sink driver, updates just after each active edge.
    initial begin
        logic [8:0] t;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(posedge iclk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (irst) src_q[k].delete();
            end
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() > 0) begin
                    t = src_q[k][0];
                    s_axis_tdata[8*k +: 8] = t[7:0];
                    s_axis_tlast[k]  = t[8];
                    s_axis_tvalid[k] = !gap || ($urandom % 4 != 0);
                end else begin
                    s_axis_tdata[8*k +: 8] = 8'h00;
                    s_axis_tlast[k]  = 1'b0;
                    s_axis_tvalid[k] = 1'b0;
                end
            end
            m_axis_tready = rdy_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        int cur;
        int rem;
        int hid;
        logic pv;
        logic pr;
        logic [7:0] pd;
        cur = -1;
        rem = 0;
        pv  = 1'b0;
        pr  = 1'b0;
        pd  = '0;
        forever begin
            @(negedge iclk);
            fire = s_axis_tvalid & s_axis_tready;
            if (irst) begin
                for (int k = 0; k < N; k++) begin
                    exp_q[k].delete();
                    flen[k].delete();
                end
                order_q.delete();
                cur = -1;
                pv  = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("stall_valid", m_axis_tvalid, 1);
                    chk("stall_data", m_axis_tdata, pd);
                end
                pv = m_axis_tvalid;
                pr = m_axis_tready;
                pd = m_axis_tdata;
                if (s_axis_tready != '0) begin
                    chk("sready_onehot", $onehot(s_axis_tready), 1);
                    chk("sready_owner", (s_axis_tready & ~ogrant) == '0, 1);
                    chk("sready_drain", !m_axis_tvalid || m_axis_tready, 1);
                end
                chk("busy_vs_grant", obusy, |ogrant);
                if (m_axis_tvalid && m_axis_tready) begin
                    beats++;
                    if (cur < 0) begin
                        hid = int'(m_axis_tdata[3:0]);
                        chk("hdr_base", m_axis_tdata[7:4], 4'hA);
                        if (hid >= N || flen[hid].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got header %0h, required none",
                                     m_axis_tdata);
                        end else begin
                            chk("hdr_grant", ogrant, 1 << hid);
                            if (order_q.size() > 0)
                                chk("rr_order", hid, order_q.pop_front());
                            rem = flen[hid].pop_front();
                            chk("hdr_byte", m_axis_tdata, exp_q[hid].pop_front());
                            rem--;
                            cur = hid;
                        end
                    end else begin
                        if (exp_q[cur].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL extra_byte: got %0h, required none",
                                     m_axis_tdata);
                        end else begin
                            chk("frame_byte", m_axis_tdata, exp_q[cur].pop_front());
                        end
                        rem--;
                        if (rem == 0) cur = -1;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b0;
        int busy_cnt;

        do_reset();

        // 1: three-byte packet on src0, header one cycle after request.
        pkt = '{8'h11, 8'h22, 8'h33};
        send(0);
        @(negedge iclk);
        chk("t1_no_early_hdr", m_axis_tvalid, 0);
        @(negedge iclk);
        chk("t1_hdr_valid", m_axis_tvalid, 1);
        chk("t1_hdr_data", m_axis_tdata, 8'hA0);
        wait_idle("t1_done", 200);

        // 2: simultaneous src1/src2, then src3 pending beats src1.
        do_reset();
        order_q.push_back(1);
        order_q.push_back(2);
        order_q.push_back(3);
        order_q.push_back(1);
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
        send(1);
        pkt = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        send(2);
        n = 0;
        while (n < 200 && ogrant != 4'b0100) begin
            @(negedge iclk);
            n++;
        end
        chk("t2_src2_grant", ogrant, 4'b0100);
        pkt = '{8'hC1, 8'hC2};
        send(1);
        pkt = '{8'hD3};
        send(3);
        wait_idle("t2_done", 400);
        chk("t2_order_used", order_q.size(), 0);

        // 3: 70-byte packet splits into 64 + 6 payload frames.
        b0 = beats;
        pkt.delete();
        for (int i = 0; i < 70; i++) pkt.push_back(8'($urandom));
        send(0);
        wait_idle("t3_done", 1000);
        chk("t3_split_beats", beats - b0, 74);

        // 4: same stream as test 1 with a random sink.
        rdy_rand = 1'b1;
        pkt = '{8'h11, 8'h22, 8'h33};
        send(0);
        wait_idle("t4_done", 500);

        // 5: reset mid-frame of src2, pointer restarts at 0.
        rdy_rand = 1'b0;
        do_reset();
        pkt = '{8'hE1, 8'hE2, 8'hE3};
        send(1);
        wait_idle("t5_pre", 200);
        pkt.delete();
        for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom));
        send(2);
        n = 0;
        while (n < 200 && !s_axis_tready[2]) begin
            @(negedge iclk);
            n++;
        end
        chk("t5_in_data", s_axis_tready[2], 1);
        do_reset();
        order_q.push_back(1);
        order_q.push_back(3);
        pkt = '{8'hF3, 8'h3F};
        send(3);
        pkt = '{8'hF1};
        send(1);
        wait_idle("t5_done", 300);
        chk("t5_order_used", order_q.size(), 0);

        // 6: single-byte packet, obusy for at least four cycles.
        pkt = '{8'h5A};
        send(0);
        busy_cnt = 0;
        n = 0;
        while (n < 100 && (busy_cnt == 0 || obusy)) begin
            @(negedge iclk);
            if (obusy) busy_cnt++;
            n++;
        end
        chk("t6_busy_ge4", busy_cnt >= 4, 1);
        wait_idle("t6_done", 100);

        // Random traffic: all sources, lengths across the split boundary.
        rdy_rand = 1'b1;
        gap = 1'b1;
        for (int r = 0; r < 30; r++) begin
            pkt.delete();
            n = $urandom_range(1, 80);
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            send($urandom_range(0, N - 1));
            if (r % 6 == 5) wait_idle("rand_done", 5000);
            else repeat ($urandom_range(0, 20)) @(negedge iclk);
        end
        wait_idle("rand_final", 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
